digit_scan: RTL and testbench

- Parametrised multiplexed seven-segment display driver; successor to the fixed 4-digit scanner.
- Scans DIGITS common-select lines with per-digit hex/raw mode, decimal point, enable, blink, and global PWM brightness.
- Emits a frame tick.
- Sits between the SoC digit-control registers and the SEG/SEGCS pins.

---
 rtl/digit_scan.sv | 168 ++++++++++++++++
 tb/tb_digit_scan.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/digit_scan.sv
// Multiplexed seven-segment scanner: per-digit hex/raw decode, blink,
// anti-ghost guard band and global PWM brightness, with a frame tick.
module digit_scan #(
   parameter int DIGITS       = 4,
   parameter int SCAN_DIV     = 12500,
   parameter int GUARD        = 2,
   parameter int PWM_BITS     = 4,
   parameter int BLINK_FRAMES = 64,
   parameter bit SEG_ACT_LOW  = 1'b1,
   parameter bit CS_ACT_LOW   = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   dig_val,
   input  logic [8*DIGITS-1:0]   raw_seg,
   input  logic [DIGITS-1:0]     raw_sel,
   input  logic [DIGITS-1:0]     dig_dot,
   input  logic [DIGITS-1:0]     dig_ena,
   input  logic [DIGITS-1:0]     dig_blink,
   input  logic [PWM_BITS-1:0]   brightness,
   output logic [7:0]            seg_out,
   output logic [DIGITS-1:0]     segcs_out,
   output logic                  frame_tick
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int AW = DW + PWM_BITS + 1;
   localparam logic [7:0] SEG_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;
   localparam logic [DIGITS-1:0] CS_OFF = CS_ACT_LOW ? '1 : '0;

   logic [DW-1:0]     div_q, div_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [FW-1:0]     frame_cnt_q, frame_cnt_d;
   logic              blink_phase_q, blink_phase_d;
   logic              tick_q, tick_d;
   logic [3:0]        val_q, val_d;
   logic [7:0]        raw_q, raw_d;
   logic              rsel_q, rsel_d;
   logic              dot_q, dot_d;
   logic              ena_q, ena_d;
   logic              blk_q, blk_d;
   logic [DW:0]       on_len_q, on_len_d;
   logic [7:0]        seg_q, seg_d;
   logic [DIGITS-1:0] cs_q, cs_d;

   logic              slot_end, last_dig, frame_end, on;
   logic [IW-1:0]     nidx;
   logic [AW-1:0]     prod;
   logic [7:0]        hex, pat;
   logic [DIGITS-1:0] cs_on;

   always_comb begin
      slot_end  = (div_q == DW'(SCAN_DIV - 1));
      last_dig  = (idx_q == IW'(DIGITS - 1));
      frame_end = slot_end && last_dig;
      nidx      = last_dig ? '0 : idx_q + IW'(1);
      div_d     = slot_end ? '0 : div_q + DW'(1);
      idx_d     = slot_end ? nidx : idx_q;
      tick_d    = frame_end;

      frame_cnt_d   = frame_cnt_q;
      blink_phase_d = blink_phase_q;
      if (frame_end) begin
         if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
            frame_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            frame_cnt_d = frame_cnt_q + FW'(1);
         end
      end

      // Latch the upcoming digit at the slot boundary so mid-slot writes never tear
      val_d    = val_q;
      raw_d    = raw_q;
      rsel_d   = rsel_q;
      dot_d    = dot_q;
      ena_d    = ena_q;
      blk_d    = blk_q;
      prod     = (AW'(brightness) + AW'(1)) * AW'(SCAN_DIV);
      on_len_d = slot_end ? (DW+1)'(prod >> PWM_BITS) : on_len_q;
      if (slot_end) begin
         for (int i = 0; i < DIGITS; i++) begin
            if (nidx == IW'(i)) begin
               val_d  = dig_val[4*i +: 4];
               raw_d  = raw_seg[8*i +: 8];
               rsel_d = raw_sel[i];
               dot_d  = dig_dot[i];
               ena_d  = dig_ena[i];
               blk_d  = dig_blink[i];
            end
         end
      end
   end

   always_comb begin
      case (val_q)
         4'h0:    hex = 8'h3F;
         4'h1:    hex = 8'h06;
         4'h2:    hex = 8'h5B;
         4'h3:    hex = 8'h4F;
         4'h4:    hex = 8'h66;
         4'h5:    hex = 8'h6D;
         4'h6:    hex = 8'h7D;
         4'h7:    hex = 8'h07;
         4'h8:    hex = 8'h7F;
         4'h9:    hex = 8'h6F;
         4'hA:    hex = 8'h77;
         4'hB:    hex = 8'h7C;
         4'hC:    hex = 8'h39;
         4'hD:    hex = 8'h5E;
         4'hE:    hex = 8'h79;
         default: hex = 8'h71;
      endcase
      pat = rsel_q ? raw_q : {dot_q, hex[6:0]};

      on = ena_q && !(blk_q && blink_phase_q)
         && ({1'b0, div_q} >= (DW+1)'(GUARD))
         && ({1'b0, div_q} < on_len_q);

      cs_on = '0;
      for (int i = 0; i < DIGITS; i++) begin
         cs_on[i] = on && (idx_q == IW'(i));
      end
      seg_d = SEG_ACT_LOW ? ~(on ? pat : 8'h00) : (on ? pat : 8'h00);
      cs_d  = CS_ACT_LOW ? ~cs_on : cs_on;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q         <= '0;
         idx_q         <= '0;
         frame_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         tick_q        <= 1'b0;
         val_q         <= '0;
         raw_q         <= '0;
         rsel_q        <= 1'b0;
         dot_q         <= 1'b0;
         ena_q         <= 1'b0;
         blk_q         <= 1'b0;
         on_len_q      <= '0;
         seg_q         <= SEG_OFF;
         cs_q          <= CS_OFF;
      end else begin
         div_q         <= div_d;
         idx_q         <= idx_d;
         frame_cnt_q   <= frame_cnt_d;
         blink_phase_q <= blink_phase_d;
         tick_q        <= tick_d;
         val_q         <= val_d;
         raw_q         <= raw_d;
         rsel_q        <= rsel_d;
         dot_q         <= dot_d;
         ena_q         <= ena_d;
         blk_q         <= blk_d;
         on_len_q      <= on_len_d;
         seg_q         <= seg_d;
         cs_q          <= cs_d;
      end
   end

   assign seg_out    = seg_q;
   assign segcs_out  = cs_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_digit_scan.sv
// Bench for digit_scan: directed phases plus random traffic, every cycle
// compared against a time-indexed model of the scan.
module tb_digit_scan;

   localparam int D  = 4;
   localparam int SD = 8;
   localparam int GD = 1;
   localparam int PB = 3;
   localparam int BF = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [15:0]   dig_val = '0;
   logic [31:0]   raw_seg = '0;
   logic [3:0]    raw_sel = '0;
   logic [3:0]    dig_dot = '0;
   logic [3:0]    dig_ena = '0;
   logic [3:0]    dig_blink = '0;
   logic [2:0]    brightness = '0;
   logic [7:0]    seg_out;
   logic [3:0]    segcs_out;
   logic          frame_tick;

   digit_scan #(
      .DIGITS(D), .SCAN_DIV(SD), .GUARD(GD), .PWM_BITS(PB),
      .BLINK_FRAMES(BF), .SEG_ACT_LOW(1'b1), .CS_ACT_LOW(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .dig_val(dig_val), .raw_seg(raw_seg),
      .raw_sel(raw_sel), .dig_dot(dig_dot), .dig_ena(dig_ena),
      .dig_blink(dig_blink), .brightness(brightness),
      .seg_out(seg_out), .segcs_out(segcs_out), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] pat;
      bit         ena;
      bit         blk;
      int         on_len;
   } snap_t;

   logic [7:0] hex_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D,
      8'h7D, 8'h07, 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

   int    vectors = 0;
   int    miscompares = 0;
   int    t = 0;
   snap_t cur;
   int    lit_cnt [4];

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h (t=%0d)", tag, got, exp, t);
      end
   endtask

   function automatic snap_t take(int d);
      snap_t s;
      logic [3:0] v;
      v = dig_val[4*d +: 4];
      s.pat = raw_sel[d] ? raw_seg[8*d +: 8]
                         : (hex_tab[v] | (dig_dot[d] ? 8'h80 : 8'h00));
      s.ena    = dig_ena[d];
      s.blk    = dig_blink[d];
      s.on_len = ((int'(brightness) + 1) * SD) >> PB;
      return s;
   endfunction

   // One clock: predict outputs from the model's position in the frame,
   // advance the model, then compare the DUT just after the edge.
   task automatic step();
      logic [7:0] e_seg;
      logic [3:0] e_cs;
      logic       e_tick;
      int dv, dig, ph;
      bit lit;
      if (rst) begin
         e_seg = 8'hFF; e_cs = 4'hF; e_tick = 1'b0;
         cur.pat = '0; cur.ena = 0; cur.blk = 0; cur.on_len = 0;
         t = 0;
      end else begin
         dv  = t % SD;
         dig = (t / SD) % D;
         ph  = ((t / (D*SD)) / BF) % 2;
         lit = cur.ena && !(cur.blk && ph == 1) && dv >= GD && dv < cur.on_len;
         e_seg  = lit ? ~cur.pat : 8'hFF;
         e_cs   = lit ? ~(4'b0001 << dig) : 4'hF;
         e_tick = ((t + 1) % (D*SD)) == 0;
         if ((t + 1) % SD == 0) cur = take(((t + 1) / SD) % D);
         t++;
      end
      @(posedge clk);
      #1;
      chk("outputs", {19'd0, frame_tick, segcs_out, seg_out},
          {19'd0, e_tick, e_cs, e_seg});
      for (int i = 0; i < 4; i++)
         if (segcs_out == ~(4'b0001 << i)) lit_cnt[i]++;
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic align(int pos);
      for (int i = 0; i < 2*D*SD && (t % (D*SD)) != pos; i++) step();
   endtask

   task automatic clear_cnt();
      for (int i = 0; i < 4; i++) lit_cnt[i] = 0;
   endtask

   initial begin
      int exp0, ph;
      // reset and idle: all enables low
      run(3);
      rst = 1'b0;
      brightness = 3'd7;
      run(70);

      // hex scan
      dig_val = 16'h3210; dig_ena = 4'hF; dig_dot = 4'b0100;
      run(40);
      align(0);
      clear_cnt();
      run(D*SD);
      for (int i = 0; i < 4; i++) chk("hex_lit_cycles", lit_cnt[i], 7);

      // raw digit 1 at reduced brightness
      raw_sel = 4'b0010; raw_seg = 32'h0000_A500; brightness = 3'd3;
      run(40);
      align(0);
      clear_cnt();
      run(D*SD);
      chk("raw_lit_cycles", lit_cnt[1], 3);
      chk("dim_lit_cycles", lit_cnt[3], 3);

      // minimum brightness: fully dark
      brightness = 3'd0;
      run(40);
      align(0);
      clear_cnt();
      run(D*SD);
      chk("dark_total", lit_cnt[0] + lit_cnt[1] + lit_cnt[2] + lit_cnt[3], 0);

      // blink digit 0
      raw_sel = 4'b0000; brightness = 3'd7; dig_blink = 4'b0001;
      run(40);
      for (int f = 0; f < 5; f++) begin
         align(0);
         ph = ((t / (D*SD)) / BF) % 2;
         exp0 = (ph == 1) ? 0 : 7;
         clear_cnt();
         run(D*SD);
         chk("blink_d0", lit_cnt[0], exp0);
         chk("blink_d2", lit_cnt[2], 7);
      end
      dig_blink = 4'b0000;

      // snapshot stability: change digit 1 mid-slot
      run(40);
      align(11);
      dig_val = 16'h3290;
      align(15);
      step();
      chk("snap_old", seg_out, 8'hF9);
      align(15);
      step();
      chk("snap_new", seg_out, 8'h90);

      // reset mid-slot at idx 2, div 5
      align(21);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_cs", segcs_out, 4'hF);
      run(80);

      // random traffic with occasional resets
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(3) == 0) begin
            dig_val    = 16'($urandom);
            raw_seg    = $urandom;
            raw_sel    = 4'($urandom);
            dig_dot    = 4'($urandom);
            dig_ena    = 4'($urandom);
            dig_blink  = 4'($urandom);
            brightness = 3'($urandom_range(7));
         end
         rst = ($urandom_range(199) == 0);
         step();
      end
      rst = 1'b0;
      run(5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
